nave_ctrl: RTL and testbench
============================

NAVE_CTRL -- requirements
Module: nave_ctrl

Interface
REQ-001 Parameter STEP, 4: ship X movement in pixels per frame.
REQ-002 Parameter X_MIN, 0: leftmost legal posX.
REQ-003 Parameter X_MAX, 618: rightmost legal posX (640 - 22 px ship width).
REQ-004 Parameter X_RESET, 309: posX after reset.
REQ-005 Parameter SHIP_Y, 490: ship top row, used for the shot launch row.
REQ-006 Parameter SHOT_STEP, 8: shot upward movement in pixels per frame.
REQ-007 Parameter COOLDOWN, 8: frames between shot end and re-arm.
REQ-008 clk  in  1  system clock; the single clock, all state on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 btn_A  in  1  move left, active-high, asynchronous to clk.
REQ-011 btn_B  in  1  move right, active-high, asynchronous to clk.
REQ-012 btn_C  in  1  fire, active-high, asynchronous to clk.
REQ-013 h_counter  in  10  current VGA column.
REQ-014 v_counter  in  10  current VGA row.
REQ-015 hit  in  1  single-cycle pulse, active shot collided.
REQ-016 posX  out  11  registered ship left X, feeds the ship renderer.
REQ-017 shot_valid  out  1  registered, shot on screen.
REQ-018 shot_x  out  11  registered shot left X.
REQ-019 shot_y  out  10  registered shot top Y.
REQ-020 frame_tick  out  1  registered one-cycle pulse per frame.

Function
REQ-021 Each button SHALL pass through a 2-flop synchronizer; all logic uses the synchronized values only.
REQ-022 frame_tick SHALL pulse for exactly one clk on the first cycle where h_counter==0 and v_counter==0 after a cycle where that was false (registered-compare edge detect), 1 cycle after the match is visible.
REQ-023 State updates other than synchronizers, hit handling and frame_tick generation SHALL occur only on cycles where the internal tick is high.
REQ-024 On tick with A=1, B=0: posX = max(posX - STEP, X_MIN), with no unsigned underflow.
REQ-025 On tick with B=1, A=0: posX = min(posX + STEP, X_MAX).
REQ-026 On tick with A=B (both or neither): posX unchanged.
REQ-027 Shot FSM states: IDLE, FLYING, COOL; encoding free.
REQ-028 IDLE: on tick with fire=1 and armed=1 -> FLYING; shot_x=posX+10 (pre-move posX); shot_y=SHIP_Y-4; shot_valid=1; armed cleared.
REQ-029 armed SHALL be set on any tick where fire=0 (re-fire requires release; holding C yields one shot).
REQ-030 FLYING: on tick, if shot_y < SHOT_STEP -> COOL with shot_valid=0; else shot_y -= SHOT_STEP; shot_x is held.
REQ-031 FLYING: hit=1 on any cycle -> COOL next cycle, shot_valid=0, without waiting for a tick; hit outside FLYING is ignored.
REQ-032 hit and tick in the same cycle: hit wins, and shot_y is not updated.
REQ-033 COOL: a frame counter loads COOLDOWN-1 on entry and decrements per tick; on the tick it reads 0 -> IDLE; a shot may launch no earlier than the next tick.
REQ-034 Ship movement continues in every FSM state; shot_x is not tied to later ship motion.

Reset
REQ-035 reset=1 asynchronously forces: posX=X_RESET, state=IDLE, shot_valid=0, shot_x=0, shot_y=0, frame_tick=0, armed=1, cooldown counter=0, synchronizers=0.
REQ-036 Reset mid-flight SHALL kill the shot immediately; no tick is required after deassert.

Verification
REQ-037 Reset, then 3 frames with btn_B=1 -> posX 309, 313, 317, 321 at successive ticks.
REQ-038 posX=2, btn_A held for 2 frames -> posX=0 then stays 0; posX=616, btn_B held -> 618 then stays 618.
REQ-039 btn_A=btn_B=1 for 5 frames -> posX unchanged, frame_tick exactly 5 single-cycle pulses.
REQ-040 posX=309, btn_C pressed and held for 3 frames -> shot_valid=1, shot_x=319, shot_y=486, 478, 470; no second shot while held.
REQ-041 Shot flying, hit pulse -> shot_valid=0 the next cycle; btn_C released then pressed -> no launch before 8 ticks have elapsed in COOL, launch on the first tick after that.
REQ-042 Reset asserted mid-flight between ticks -> shot_valid=0 and posX=309 within the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/nave_ctrl.sv
// nave_ctrl: player ship controller for the VGA shooter.
// Moves the ship left/right once per frame from two buttons, launches a single
// shot from a third button and flies it upward until it leaves the top of the
// screen or a collision pulse kills it. A cooldown enforces a pause between shots.
module nave_ctrl #(
    parameter int STEP      = 4,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 618,
    parameter int X_RESET   = 309,
    parameter int SHIP_Y    = 490,
    parameter int SHOT_STEP = 8,
    parameter int COOLDOWN  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_A,
    input  logic        btn_B,
    input  logic        btn_C,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    input  logic        hit,
    output logic [10:0] posX,
    output logic        shot_valid,
    output logic [10:0] shot_x,
    output logic [9:0]  shot_y,
    output logic        frame_tick
);

    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [10:0]      STEP_V      = 11'(STEP);
    localparam logic [10:0]      X_MIN_V     = 11'(X_MIN);
    localparam logic [10:0]      X_MAX_V     = 11'(X_MAX);
    localparam logic [10:0]      X_RESET_V   = 11'(X_RESET);
    localparam logic [10:0]      SHOT_OFS    = 11'd10;
    localparam logic [9:0]       LAUNCH_Y    = 10'(SHIP_Y - 4);
    localparam logic [9:0]       SHOT_STEP_V = 10'(SHOT_STEP);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLYING,
        S_COOL
    } shot_state_t;

    // Synchronizer stages: bit 0 = A (left), bit 1 = B (right), bit 2 = C (fire)
    logic [2:0]  sync_meta_d, sync_meta_q;
    logic [2:0]  sync_d, sync_q;

    logic        match_d, match_q;
    logic        frame_tick_d, frame_tick_q;

    logic [10:0] pos_x_d, pos_x_q;

    shot_state_t state_d, state_q;
    logic        shot_valid_d, shot_valid_q;
    logic [10:0] shot_x_d, shot_x_q;
    logic [9:0]  shot_y_d, shot_y_q;
    logic        armed_d, armed_q;
    logic [CNT_W-1:0] cool_cnt_d, cool_cnt_q;

    logic        move_left;
    logic        move_right;
    logic        fire;

    // Button synchronizers and the frame-start edge detector on the VGA counters
    always_comb begin
        sync_meta_d  = {btn_C, btn_B, btn_A};
        sync_d       = sync_meta_q;
        match_d      = (h_counter == 10'd0) && (v_counter == 10'd0);
        frame_tick_d = match_d && !match_q;
    end

    // Ship movement once per frame; opposing or idle buttons leave the ship still
    always_comb begin
        move_left  = sync_q[0] && !sync_q[1];
        move_right = sync_q[1] && !sync_q[0];
        pos_x_d    = pos_x_q;
        if (frame_tick_q) begin
            if (move_left) begin
                pos_x_d = (pos_x_q < X_MIN_V + STEP_V) ? X_MIN_V : pos_x_q - STEP_V;
            end else if (move_right) begin
                pos_x_d = (pos_x_q + STEP_V > X_MAX_V) ? X_MAX_V : pos_x_q + STEP_V;
            end
        end
    end

    // Shot FSM next-state: launch, flight, collision kill and cooldown re-arm
    always_comb begin
        fire         = sync_q[2];
        state_d      = state_q;
        shot_valid_d = shot_valid_q;
        shot_x_d     = shot_x_q;
        shot_y_d     = shot_y_q;
        armed_d      = armed_q;
        cool_cnt_d   = cool_cnt_q;

        if (frame_tick_q && !fire) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick_q && fire && armed_q) begin
                    state_d      = S_FLYING;
                    shot_x_d     = pos_x_q + SHOT_OFS;
                    shot_y_d     = LAUNCH_Y;
                    shot_valid_d = 1'b1;
                    armed_d      = 1'b0;
                end
            end
            S_FLYING: begin
                if (hit) begin
                    state_d      = S_COOL;
                    shot_valid_d = 1'b0;
                    cool_cnt_d   = COOL_LOAD;
                end else if (frame_tick_q) begin
                    if (shot_y_q < SHOT_STEP_V) begin
                        state_d      = S_COOL;
                        shot_valid_d = 1'b0;
                        cool_cnt_d   = COOL_LOAD;
                    end else begin
                        shot_y_d = shot_y_q - SHOT_STEP_V;
                    end
                end
            end
            S_COOL: begin
                if (frame_tick_q) begin
                    if (cool_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cool_cnt_d = cool_cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                shot_valid_d = 1'b0;
            end
        endcase
    end

    // State register for all flops; reset kills any shot in flight immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_q  <= '0;
            sync_q       <= '0;
            match_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            pos_x_q      <= X_RESET_V;
            state_q      <= S_IDLE;
            shot_valid_q <= 1'b0;
            shot_x_q     <= '0;
            shot_y_q     <= '0;
            armed_q      <= 1'b1;
            cool_cnt_q   <= '0;
        end else begin
            sync_meta_q  <= sync_meta_d;
            sync_q       <= sync_d;
            match_q      <= match_d;
            frame_tick_q <= frame_tick_d;
            pos_x_q      <= pos_x_d;
            state_q      <= state_d;
            shot_valid_q <= shot_valid_d;
            shot_x_q     <= shot_x_d;
            shot_y_q     <= shot_y_d;
            armed_q      <= armed_d;
            cool_cnt_q   <= cool_cnt_d;
        end
    end

    assign posX       = pos_x_q;
    assign shot_valid = shot_valid_q;
    assign shot_x     = shot_x_q;
    assign shot_y     = shot_y_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_nave_ctrl.sv
// tb_nave_ctrl: frame-based scoreboard bench for nave_ctrl.
// Each stimulus frame pushes the expected post-tick state; the monitor pops
// and compares it right after the DUT performs its per-frame update.
module tb_nave_ctrl;

    localparam int STEP    = 4;
    localparam int X_MIN   = 0;
    localparam int X_MAX   = 618;
    localparam int X_RESET = 309;

    logic        clk;
    logic        reset;
    logic        btn_A;
    logic        btn_B;
    logic        btn_C;
    logic [9:0]  h_counter;
    logic [9:0]  v_counter;
    logic        hit;
    logic [10:0] posX;
    logic        shot_valid;
    logic [10:0] shot_x;
    logic [9:0]  shot_y;
    logic        frame_tick;

    typedef struct {
        int pos;
        bit chk_v;
        bit exp_v;
        bit chk_xy;
        int sx;
        int sy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   tick_count = 0;
    int   tick_base  = 0;
    int   m_pos      = X_RESET;
    bit   tick_seen  = 1'b0;
    bit   monitor_on = 1'b0;

    nave_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn_A      (btn_A),
        .btn_B      (btn_B),
        .btn_C      (btn_C),
        .h_counter  (h_counter),
        .v_counter  (v_counter),
        .hit        (hit),
        .posX       (posX),
        .shot_valid (shot_valid),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .frame_tick (frame_tick)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // One frame: push expected post-tick state, drive buttons, then a two-cycle
    // h/v==0 window that must yield a single tick. hit_mode 1 pulses hit mid-frame,
    // hit_mode 2 pulses it in the same cycle the tick takes effect.
    task automatic applyStimulus(input logic a, input logic b, input logic c,
                                 input int hit_mode, input bit chk_v, input bit exp_v,
                                 input bit chk_xy, input int sx, input int sy);
        exp_t e;
        if (a && !b) begin
            m_pos = (m_pos - STEP < X_MIN) ? X_MIN : m_pos - STEP;
        end else if (b && !a) begin
            m_pos = (m_pos + STEP > X_MAX) ? X_MAX : m_pos + STEP;
        end
        e.pos    = m_pos;
        e.chk_v  = chk_v;
        e.exp_v  = exp_v;
        e.chk_xy = chk_xy;
        e.sx     = sx;
        e.sy     = sy;
        sb.push_back(e);

        btn_A     = a;
        btn_B     = b;
        btn_C     = c;
        h_counter = 10'd5;
        v_counter = 10'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (hit_mode == 1 && i == 0) hit = 1'b1;
            if (hit_mode == 1 && i == 1) begin
                checkOutput("hit_kill_valid", shot_valid, 0);
                hit = 1'b0;
            end
        end
        h_counter = 10'd0;
        v_counter = 10'd0;
        @(negedge clk);
        if (hit_mode == 2) hit = 1'b1;
        @(negedge clk);
        hit       = 1'b0;
        h_counter = 10'd5;
        @(negedge clk);
    endtask

    // Monitor: the negedge after a tick is seen, the frame update has happened
    always @(negedge clk) begin
        if (reset || !monitor_on) begin
            tick_seen = 1'b0;
        end else begin
            if (tick_seen) begin
                checkOutput("tick_width", frame_tick, 0);
                checkOutput("tick_expected", sb.size(), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    checkOutput("posX", posX, mon_e.pos);
                    if (mon_e.chk_v) checkOutput("shot_valid", shot_valid, mon_e.exp_v);
                    if (mon_e.chk_xy) begin
                        checkOutput("shot_x", shot_x, mon_e.sx);
                        checkOutput("shot_y", shot_y, mon_e.sy);
                    end
                end
            end
            tick_seen = frame_tick;
            if (frame_tick) tick_count++;
        end
    end

    // Main sequence
    initial begin
        reset     = 1'b1;
        btn_A     = 1'b0;
        btn_B     = 1'b0;
        btn_C     = 1'b0;
        hit       = 1'b0;
        h_counter = 10'd5;
        v_counter = 10'd3;
        repeat (3) @(negedge clk);
        checkOutput("rst_posX", posX, X_RESET);
        checkOutput("rst_shot_valid", shot_valid, 0);
        checkOutput("rst_shot_x", shot_x, 0);
        checkOutput("rst_shot_y", shot_y, 0);
        checkOutput("rst_frame_tick", frame_tick, 0);
        reset      = 1'b0;
        m_pos      = X_RESET;
        monitor_on = 1'b1;

        $display("[TB] shot launch and hold");
        applyStimulus(0, 0, 1, 0, 1, 1, 1, 319, 486);
        applyStimulus(0, 0, 1, 0, 1, 1, 1, 319, 478);
        applyStimulus(0, 0, 1, 0, 1, 1, 1, 319, 470);

        $display("[TB] hit kill and cooldown boundary");
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 1, 1, 1, 319, 486);
        applyStimulus(0, 1, 1, 0, 1, 1, 1, 319, 478);

        $display("[TB] hit with tick, held fire after cooldown");
        applyStimulus(0, 0, 1, 2, 1, 0, 1, 319, 478);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 1, 1, 327, 486);

        $display("[TB] asynchronous reset mid-flight");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_valid", shot_valid, 0);
        checkOutput("async_rst_posX", posX, X_RESET);
        checkOutput("async_rst_shot_y", shot_y, 0);
        @(negedge clk);
        reset = 1'b0;
        m_pos = X_RESET;

        $display("[TB] move right three frames");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("pos_after_3_right", posX, 321);

        $display("[TB] both buttons for five frames");
        tick_base = tick_count;
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("tick_count_5", tick_count - tick_base, 5);

        $display("[TB] walk to left and right limits");
        while (m_pos > X_MIN) applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("clamp_low_hold", posX, 0);
        while (m_pos < 616) applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("at_616", posX, 616);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("clamp_high_hold", posX, 618);
        while (m_pos > 2) applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("at_2", posX, 2);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("clamp_low_from_2", posX, 0);

        repeat (3) @(negedge clk);
        checkOutput("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
